// File: rtl/hormado_scheduler.sv
// Round-robin arbiter and sequencer for the shared hormado station: validates recipe, runs FORM/COOL dwell, reports done/rej.
// Optional abort input (FORM/COOL -> IDLE with rej) compiled in when HORMADO_ABORT_EN is defined.
module hormado_scheduler #(
   parameter int NREQ  = 3,
   parameter int TFORM = 8,
   parameter int TCOOL = 2,
   parameter int CW    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] pls,
   input  logic [3*NREQ-1:0] typ,
   input  logic              stop,
`ifdef HORMADO_ABORT_EN
   input  logic              abort,
`endif
   output logic [NREQ-1:0]   gnt,
   output logic              ph,
   output logic              busy,
   output logic [NREQ-1:0]   rej,
   output logic [NREQ-1:0]   done,
   output logic [CW-1:0]     count
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TMAX = (TFORM > TCOOL) ? TFORM : TCOOL;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] FORM_LAST = TW'(TFORM - 1);
   localparam logic [TW-1:0] COOL_LAST = TW'(TCOOL - 1);

   typedef enum logic [1:0] {IDLE, FORM, COOL, DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              ph_q, ph_d;
   logic              busy_q, busy_d;
   logic [NREQ-1:0]   rej_q, rej_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [CW-1:0]     count_q, count_d;

   logic              win_vld;
   logic [IW-1:0]     win_idx;
   logic              win_ok;
   logic [NREQ-1:0]   win_oh;
   logic [NREQ-1:0]   idx_oh;
   int                j;

   function automatic logic recipe_ok(input logic [1:0] p, input logic [2:0] t);
      case ({p, t})
         5'b01_001, 5'b10_001, 5'b01_010, 5'b01_100, 5'b10_100: recipe_ok = 1'b1;
         default:                                               recipe_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
      next_ptr = (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
   endfunction

   // First requesting line at or after the pointer, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_vld && req[j]) begin
            win_vld = 1'b1;
            win_idx = IW'(j);
         end
      end
   end

   assign win_ok = recipe_ok(pls[2*int'(win_idx) +: 2], typ[3*int'(win_idx) +: 3]);
   assign win_oh = NREQ'(1) << win_idx;
   assign idx_oh = NREQ'(1) << idx_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      tmr_d   = tmr_q;
      gnt_d   = gnt_q;
      ph_d    = ph_q;
      busy_d  = busy_q;
      rej_d   = '0;
      done_d  = '0;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            ph_d   = 1'b0;
            busy_d = 1'b0;
            // A refused line still holds req during its rej cycle; skip that cycle.
            if (!stop && win_vld && (rej_q == '0)) begin
               if (win_ok) begin
                  state_d = FORM;
                  idx_d   = win_idx;
                  gnt_d   = win_oh;
                  ph_d    = 1'b1;
                  busy_d  = 1'b1;
                  tmr_d   = '0;
               end else begin
                  rej_d = win_oh;
                  ptr_d = next_ptr(win_idx);
               end
            end
         end
         FORM: begin
            if (tmr_q == FORM_LAST) begin
               state_d = COOL;
               tmr_d   = '0;
               ph_d    = 1'b0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         COOL: begin
            if (tmr_q == COOL_LAST) begin
               state_d = DONE;
               tmr_d   = '0;
               gnt_d   = '0;
               done_d  = idx_oh;
               count_d = count_q + CW'(1);
               ptr_d   = next_ptr(idx_q);
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
`ifdef HORMADO_ABORT_EN
      if (abort && ((state_q == FORM) || (state_q == COOL))) begin
         state_d = IDLE;
         tmr_d   = '0;
         gnt_d   = '0;
         ph_d    = 1'b0;
         busy_d  = 1'b0;
         rej_d   = idx_oh;
         done_d  = '0;
         count_d = count_q;
         ptr_d   = next_ptr(idx_q);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         tmr_q   <= '0;
         gnt_q   <= '0;
         ph_q    <= 1'b0;
         busy_q  <= 1'b0;
         rej_q   <= '0;
         done_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         tmr_q   <= tmr_d;
         gnt_q   <= gnt_d;
         ph_q    <= ph_d;
         busy_q  <= busy_d;
         rej_q   <= rej_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign gnt   = gnt_q;
   assign ph    = ph_q;
   assign busy  = busy_q;
   assign rej   = rej_q;
   assign done  = done_q;
   assign count = count_q;

endmodule

// File: tb/tb_hormado_scheduler.sv
// Scoreboard bench for hormado_scheduler: expected done/rej events queued at stimulus, checked by a negedge monitor.
module tb_hormado_scheduler;

   localparam int NREQ  = 3;
   localparam int TFORM = 8;
   localparam int TCOOL = 2;
   localparam int CW    = 8;

   logic            clk;
   logic            reset;
   logic [2:0]      req;
   logic [5:0]      pls;
   logic [8:0]      typ;
   logic            stop;
`ifdef HORMADO_ABORT_EN
   logic            abort;
`endif
   logic [2:0]      gnt;
   logic            ph;
   logic            busy;
   logic [2:0]      rej;
   logic [2:0]      done;
   logic [CW-1:0]   count;

   typedef struct {
      bit is_rej;
      int line;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_chk;
   int  n_fail;
   int  exp_cnt;
   bit  mon_en;

   hormado_scheduler #(.NREQ(NREQ), .TFORM(TFORM), .TCOOL(TCOOL), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .pls   (pls),
      .typ   (typ),
      .stop  (stop),
`ifdef HORMADO_ABORT_EN
      .abort (abort),
`endif
      .gnt   (gnt),
      .ph    (ph),
      .busy  (busy),
      .rej   (rej),
      .done  (done),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] oh(input int i);
      logic [2:0] one;
      one = 3'b001;
      return one << i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every done/rej pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         n_chk++;
         if (($countones(gnt) + $countones(done) + $countones(rej)) > 1) begin
            n_fail++;
            $display("FAIL exclusive: gnt=%b done=%b rej=%b, required at most one bit set", gnt, done, rej);
         end
         if ((done !== 3'b000) || (rej !== 3'b000)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pulse: done=%b rej=%b, required none", done, rej);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_rej && ((rej !== oh(mon_e.line)) || (done !== 3'b000))) begin
                  n_fail++;
                  $display("FAIL sb_rej: rej=%b done=%b, required rej=%b done=000", rej, done, oh(mon_e.line));
               end else if (!mon_e.is_rej && ((done !== oh(mon_e.line)) || (rej !== 3'b000))) begin
                  n_fail++;
                  $display("FAIL sb_done: done=%b rej=%b, required done=%b rej=000", done, rej, oh(mon_e.line));
               end else if (count !== CW'(mon_e.cnt)) begin
                  n_fail++;
                  $display("FAIL sb_count: count=%0d, required %0d", count, mon_e.cnt);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      req   = 3'b111;
      pls   = 6'b01_01_01;
      typ   = 9'b001_001_001;
      stop  = 1'b0;
`ifdef HORMADO_ABORT_EN
      abort = 1'b0;
`endif
      tick();
      tick();
      n_chk++;
      if ((gnt !== 3'b000) || (ph !== 1'b0) || (busy !== 1'b0) || (count !== '0) || (done !== 3'b000) || (rej !== 3'b000)) begin
         n_fail++;
         $display("FAIL reset_state: gnt=%b ph=%b busy=%b count=%0d done=%b rej=%b, required all zero", gnt, ph, busy, count, done, rej);
      end
      mon_en = 1'b1;
      reset  = 1'b1;
      tick();
      n_chk++;
      if ((gnt !== 3'b001) || (ph !== 1'b1)) begin
         n_fail++;
         $display("FAIL reset_first_grant: gnt=%b ph=%b, required gnt=001 ph=1", gnt, ph);
      end
      reset = 1'b0;
      req   = 3'b000;
      tick();
      reset = 1'b1;
      tick();
      exp_cnt = 0;
   endtask

   task automatic test_single();
      req = 3'b001;
      pls = 6'b00_00_01;
      typ = 9'b000_000_001;
      tick();
      exp_cnt++;
      exp_q.push_back('{is_rej: 1'b0, line: 0, cnt: exp_cnt});
      for (int c = 1; c <= TFORM; c++) begin
         n_chk++;
         if ((ph !== 1'b1) || (gnt !== 3'b001) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL single_form%0d: ph=%b gnt=%b busy=%b, required 1 001 1", c, ph, gnt, busy);
         end
         tick();
      end
      for (int c = 1; c <= TCOOL; c++) begin
         n_chk++;
         if ((ph !== 1'b0) || (gnt !== 3'b001) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL single_cool%0d: ph=%b gnt=%b busy=%b, required 0 001 1", c, ph, gnt, busy);
         end
         tick();
      end
      n_chk++;
      if ((gnt !== 3'b000) || (busy !== 1'b1) || (done !== 3'b001) || (count !== CW'(1))) begin
         n_fail++;
         $display("FAIL single_done: gnt=%b busy=%b done=%b count=%0d, required 000 1 001 1", gnt, busy, done, count);
      end
      req = 3'b000;
      tick();
      n_chk++;
      if ((busy !== 1'b0) || (gnt !== 3'b000)) begin
         n_fail++;
         $display("FAIL single_idle: busy=%b gnt=%b, required 0 000", busy, gnt);
      end
   endtask

   task automatic test_invalid();
      req = 3'b010;
      pls = 6'b00_11_00;
      typ = 9'b000_001_000;
      exp_q.push_back('{is_rej: 1'b1, line: 1, cnt: exp_cnt});
      tick();
      n_chk++;
      if ((rej !== 3'b010) || (gnt !== 3'b000) || (ph !== 1'b0)) begin
         n_fail++;
         $display("FAIL invalid_rej: rej=%b gnt=%b ph=%b, required 010 000 0", rej, gnt, ph);
      end
      req = 3'b000;
      repeat (3) begin
         tick();
         n_chk++;
         if ((gnt !== 3'b000) || (ph !== 1'b0) || (count !== CW'(exp_cnt))) begin
            n_fail++;
            $display("FAIL invalid_after: gnt=%b ph=%b count=%0d, required 000 0 %0d", gnt, ph, count, exp_cnt);
         end
      end
   endtask

   task automatic test_round_robin();
      reset = 1'b0;
      pls   = 6'b10_10_10;
      typ   = 9'b100_100_100;
      req   = 3'b111;
      tick();
      exp_cnt = 0;
      reset   = 1'b1;
      tick();
      for (int g = 0; g < 4; g++) begin
         n_chk++;
         if (gnt !== oh(g % 3)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: gnt=%b, required %b", g, gnt, oh(g % 3));
         end
         exp_cnt++;
         exp_q.push_back('{is_rej: 1'b0, line: g % 3, cnt: exp_cnt});
         repeat (TFORM + TCOOL) tick();
         n_chk++;
         if ((gnt !== 3'b000) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL rr_done%0d: gnt=%b busy=%b, required 000 1", g, gnt, busy);
         end
         if (g == 3) begin
            n_chk++;
            if (count !== CW'(4)) begin
               n_fail++;
               $display("FAIL rr_count: count=%0d, required 4", count);
            end
            req = 3'b000;
         end
         tick();
         n_chk++;
         if ((gnt !== 3'b000) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL rr_idle%0d: gnt=%b busy=%b, required 000 0", g, gnt, busy);
         end
         if (g < 3) tick();
      end
      tick();
      n_chk++;
      if (gnt !== 3'b000) begin
         n_fail++;
         $display("FAIL rr_quiet: gnt=%b, required 000", gnt);
      end
   endtask

   task automatic test_stop();
      pls  = 6'b01_00_00;
      typ  = 9'b010_000_000;
      req  = 3'b100;
      stop = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_chk++;
         if ((gnt !== 3'b000) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL stop_hold%0d: gnt=%b busy=%b, required 000 0", c, gnt, busy);
         end
      end
      stop = 1'b0;
      tick();
      exp_cnt++;
      exp_q.push_back('{is_rej: 1'b0, line: 2, cnt: exp_cnt});
      for (int c = 1; c <= TFORM; c++) begin
         if (c == 3) stop = 1'b1;
         n_chk++;
         if ((ph !== 1'b1) || (gnt !== 3'b100)) begin
            n_fail++;
            $display("FAIL stop_form%0d: ph=%b gnt=%b, required 1 100", c, ph, gnt);
         end
         tick();
      end
      for (int c = 1; c <= TCOOL; c++) begin
         n_chk++;
         if ((ph !== 1'b0) || (gnt !== 3'b100)) begin
            n_fail++;
            $display("FAIL stop_cool%0d: ph=%b gnt=%b, required 0 100", c, ph, gnt);
         end
         tick();
      end
      n_chk++;
      if ((done !== 3'b100) || (count !== CW'(exp_cnt))) begin
         n_fail++;
         $display("FAIL stop_done: done=%b count=%0d, required 100 %0d", done, count, exp_cnt);
      end
      req  = 3'b000;
      stop = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      pls = 6'b00_00_01;
      typ = 9'b000_000_001;
      req = 3'b001;
      tick();
      n_chk++;
      if (gnt !== 3'b001) begin
         n_fail++;
         $display("FAIL rmid_grant: gnt=%b, required 001", gnt);
      end
      repeat (3) tick();
      reset = 1'b0;
      tick();
      exp_cnt = 0;
      n_chk++;
      if ((ph !== 1'b0) || (gnt !== 3'b000) || (busy !== 1'b0) || (count !== '0)) begin
         n_fail++;
         $display("FAIL rmid_state: ph=%b gnt=%b busy=%b count=%0d, required 0 000 0 0", ph, gnt, busy, count);
      end
      reset = 1'b1;
      req   = 3'b000;
      repeat (12) begin
         tick();
         n_chk++;
         if ((gnt !== 3'b000) || (count !== '0)) begin
            n_fail++;
            $display("FAIL rmid_after: gnt=%b count=%0d, required 000 0", gnt, count);
         end
      end
   endtask

`ifdef HORMADO_ABORT_EN
   task automatic test_abort();
      pls = 6'b00_01_00;
      typ = 9'b000_100_000;
      req = 3'b010;
      tick();
      n_chk++;
      if (gnt !== 3'b010) begin
         n_fail++;
         $display("FAIL abort_grant: gnt=%b, required 010", gnt);
      end
      repeat (3) tick();
      abort = 1'b1;
      exp_q.push_back('{is_rej: 1'b1, line: 1, cnt: exp_cnt});
      tick();
      abort = 1'b0;
      n_chk++;
      if ((ph !== 1'b0) || (gnt !== 3'b000) || (rej !== 3'b010) || (busy !== 1'b0)) begin
         n_fail++;
         $display("FAIL abort_state: ph=%b gnt=%b rej=%b busy=%b, required 0 000 010 0", ph, gnt, rej, busy);
      end
      req = 3'b000;
      repeat (12) begin
         tick();
         n_chk++;
         if ((gnt !== 3'b000) || (count !== CW'(exp_cnt))) begin
            n_fail++;
            $display("FAIL abort_after: gnt=%b count=%0d, required 000 %0d", gnt, count, exp_cnt);
         end
      end
   endtask
`endif

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      exp_cnt = 0;
      mon_en  = 1'b0;
      test_reset();
      test_single();
      test_invalid();
      test_round_robin();
      test_stop();
      test_reset_mid();
`ifdef HORMADO_ABORT_EN
      test_abort();
`endif
      tick();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
